dig_ct_arb_seq: RTL and testbench

DIG_CT_ARB_SEQ -- requirements
Module: dig_ct_arb_seq

---
 rtl/dig_ct_arb_seq.sv | 130 +++++++++++++
 tb/tb_dig_ct_arb_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dig_ct_arb_seq.sv
// Two-requester round-robin sequencer in front of a shared registered logic cell.
// Optional completion counters are built only when DIG_CT_ARB_STATS_EN is defined.
module dig_ct_arb_seq #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [4:0]       DIN0,
  output logic             GNT0,
  input  logic             REQ1,
  input  logic [4:0]       DIN1,
  output logic             GNT1,
  output logic [4:0]       CELL_IN,
  input  logic [2:0]       CELL_OUT,
  output logic             RSP_VLD,
  input  logic             RSP_RDY,
  output logic             RSP_ID,
  output logic [2:0]       RSP_DATA,
  output logic             BUSY,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       last_q;   // 1: requester 1 was served last, so requester 0 wins a tie
  logic       owner_q;
  logic [4:0] cell_in_q;
  logic       rsp_vld_q;
  logic       rsp_id_q;
  logic [2:0] rsp_data_q;
  logic       gnt0, gnt1;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!RST) begin
          if (REQ0 && (!REQ1 || last_q)) gnt0 = 1'b1;
          else if (REQ1)                 gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) state_d = DRIVE;
      end
      DRIVE:   state_d = SAMPLE;
      SAMPLE:  state_d = RESP;
      RESP:    if (RSP_RDY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      cell_in_q  <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            cell_in_q <= gnt1 ? DIN1 : DIN0;
            owner_q   <= gnt1;
            last_q    <= gnt1;
          end
        end
        SAMPLE: begin
          rsp_data_q <= CELL_OUT;
          rsp_id_q   <= owner_q;
          rsp_vld_q  <= 1'b1;
        end
        RESP: begin
          if (RSP_RDY) rsp_vld_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DIG_CT_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             accept;

  assign accept = (state_q == RESP) && RSP_RDY;

  // Counters saturate rather than wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (!owner_q && cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_W'(1);
      if ( owner_q && cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign CNT0 = cnt0_q;
  assign CNT1 = cnt1_q;
`else
  assign CNT0 = '0;
  assign CNT1 = '0;
`endif

  assign GNT0     = gnt0;
  assign GNT1     = gnt1;
  assign CELL_IN  = cell_in_q;
  assign RSP_VLD  = rsp_vld_q;
  assign RSP_ID   = rsp_id_q;
  assign RSP_DATA = rsp_data_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_dig_ct_arb_seq.sv
// Directed self-checking bench for dig_ct_arb_seq with a registered model of the shared cell.
// Counter expectations follow whether DIG_CT_ARB_STATS_EN is defined for the build.
module tb_dig_ct_arb_seq;

  localparam int CW = 2;
`ifdef DIG_CT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1;
  logic [4:0]    DIN0, DIN1;
  logic          GNT0, GNT1;
  logic [4:0]    CELL_IN;
  logic [2:0]    CELL_OUT;
  logic          RSP_VLD, RSP_RDY, RSP_ID;
  logic [2:0]    RSP_DATA;
  logic          BUSY;
  logic [CW-1:0] CNT0, CNT1;

  int tests_run = 0;
  int tests_failed = 0;
  int e0 = 0;
  int e1 = 0;

  dig_ct_arb_seq #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .DIN0(DIN0), .GNT0(GNT0),
    .REQ1(REQ1), .DIN1(DIN1), .GNT1(GNT1),
    .CELL_IN(CELL_IN), .CELL_OUT(CELL_OUT),
    .RSP_VLD(RSP_VLD), .RSP_RDY(RSP_RDY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
    .BUSY(BUSY), .CNT0(CNT0), .CNT1(CNT1)
  );

  always #5 CLK = ~CLK;

  // Shared cell: {OUT3,OUT2,OUT1}, one register stage.
  always @(posedge CLK)
    CELL_OUT <= {CELL_IN[4] | CELL_IN[2] | ~CELL_IN[3],
                 ~(CELL_IN[2] & CELL_IN[1]),
                 ~(CELL_IN[2] & ~(CELL_IN[0] | CELL_IN[1]))};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bump(input int who);
    if (STATS) begin
      if (who == 0 && e0 < CMAX) e0++;
      if (who == 1 && e1 < CMAX) e1++;
    end
  endtask

  initial begin
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; DIN0 = '0; DIN1 = '0; RSP_RDY = 1'b0;
    tick(); tick();

    // Reset state, and no grant while reset is high
    REQ0 = 1'b1; #1;
    check("gnt0_in_reset", GNT0, 1'b0);
    REQ0 = 1'b0;
    check("rst_cell_in", CELL_IN, 5'd0);
    check("rst_rsp_vld", RSP_VLD, 1'b0);
    check("rst_rsp_id", RSP_ID, 1'b0);
    check("rst_rsp_data", RSP_DATA, 3'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_cnt0", CNT0, 0);
    check("rst_cnt1", CNT1, 0);

    // Single transaction from requester 0
    RST = 1'b0; REQ0 = 1'b1; DIN0 = 5'b00100; RSP_RDY = 1'b1; #1;
    check("t1_gnt0", GNT0, 1'b1);
    check("t1_gnt1", GNT1, 1'b0);
    tick(); REQ0 = 1'b0;
    check("t1_busy", BUSY, 1'b1);
    check("t1_cell_in", CELL_IN, 5'b00100);
    check("t1_vld_c1", RSP_VLD, 1'b0);
    tick();
    check("t1_vld_c2", RSP_VLD, 1'b0);
    tick();
    check("t1_vld_c3", RSP_VLD, 1'b1);
    check("t1_rsp_id", RSP_ID, 1'b0);
    check("t1_rsp_data", RSP_DATA, 3'b110);
    tick(); bump(0);
    check("t1_vld_drop", RSP_VLD, 1'b0);
    check("t1_busy_idle", BUSY, 1'b0);
    check("t1_cnt0", CNT0, e0);
    check("t1_cell_hold", CELL_IN, 5'b00100);

    // Both requesting continuously: grants alternate 1,0,1,0 every 4 cycles
    REQ0 = 1'b1; REQ1 = 1'b1; DIN0 = 5'b01000; DIN1 = 5'b00100;
    for (int k = 0; k < 4; k++) begin
      automatic int g = (k % 2 == 0) ? 1 : 0;
      #1;
      check("rr_gnt0", GNT0, (g == 0));
      check("rr_gnt1", GNT1, (g == 1));
      tick(); tick(); tick();
      check("rr_vld", RSP_VLD, 1'b1);
      check("rr_id", RSP_ID, g[0]);
      check("rr_data", RSP_DATA, (g == 1) ? 3'b110 : 3'b011);
      check("rr_no_gnt_resp", {GNT1, GNT0}, 2'b00);
      tick(); bump(g);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    check("rr_cnt0", CNT0, e0);
    check("rr_cnt1", CNT1, e1);

    // Backpressure: response held stable while RSP_RDY is low
    REQ1 = 1'b1; DIN1 = 5'b00110; RSP_RDY = 1'b0; #1;
    check("bp_gnt1", GNT1, 1'b1);
    tick(); REQ1 = 1'b0;
    tick(); tick();
    REQ0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_vld", RSP_VLD, 1'b1);
      check("bp_data", RSP_DATA, 3'b101);
      check("bp_id", RSP_ID, 1'b1);
      check("bp_busy", BUSY, 1'b1);
      check("bp_no_gnt", GNT0, 1'b0);
      tick();
    end
    RSP_RDY = 1'b1; #1;
    check("bp_no_gnt_accept", GNT0, 1'b0);
    tick(); REQ0 = 1'b0; bump(1);
    check("bp_vld_drop", RSP_VLD, 1'b0);
    check("bp_busy_idle", BUSY, 1'b0);
    check("bp_cnt1", CNT1, e1);

    // Request dropped before an edge, RSP_RDY high in IDLE: no effect
    REQ0 = 1'b1; #1; REQ0 = 1'b0;
    tick();
    check("cancel_busy", BUSY, 1'b0);
    check("cancel_cnt0", CNT0, e0);
    check("cancel_cnt1", CNT1, e1);

    // Reset during SAMPLE abandons the transaction
    REQ0 = 1'b1; DIN0 = 5'b00100; #1;
    tick(); REQ0 = 1'b0;
    tick();
    RST = 1'b1;
    tick(); e0 = 0; e1 = 0;
    check("rs_vld", RSP_VLD, 1'b0);
    check("rs_cell_in", CELL_IN, 5'd0);
    check("rs_busy", BUSY, 1'b0);
    check("rs_cnt0", CNT0, 0);
    check("rs_cnt1", CNT1, 0);
    RST = 1'b0;
    tick(); tick(); tick();
    check("rs_no_rsp", RSP_VLD, 1'b0);

    // After reset, requester 0 wins the first tie
    REQ0 = 1'b1; REQ1 = 1'b1; #1;
    check("tie_gnt0", GNT0, 1'b1);
    check("tie_gnt1", GNT1, 1'b0);
    REQ1 = 1'b0;

    // Five requester-0 transactions: counter saturates at its maximum
    for (int k = 0; k < 5; k++) begin
      REQ0 = 1'b1; DIN0 = 5'b00100; #1;
      tick(); REQ0 = 1'b0;
      tick(); tick(); tick(); bump(0);
      check("sat_cnt0", CNT0, e0);
    end
    check("sat_cnt0_final", CNT0, STATS ? CMAX : 0);
    check("sat_cnt1", CNT1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
